data_mem_bytelane: RTL and testbench

- Parametrised successor to the word-only data RAM. Sits in the MEM stage of the MIPS32 pipeline.
- Adds byte and halfword loads/stores with sign/zero extension.
- Read data is registered: one-cycle synchronous read, BRAM-inferable.
- Detects misaligned accesses, drops out-of-range accesses, and keeps a memory-mapped digit register.
- Optional sequential zero-clear sweep after reset, with a busy flag that stalls the pipeline.

---
 rtl/data_mem_bytelane.sv | 142 ++++++++++++++
 tb/tb_data_mem_bytelane.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/data_mem_bytelane.sv
// Byte-lane data RAM for the MIPS32 MEM stage: registered reads, sign/zero-extended sub-word
// loads, misalign detection, MMIO digit register. `define DATA_MEM_CLEAR_ON_RST_EN for the reset sweep.
module data_mem_bytelane #(
    parameter int unsigned RAM_ADDR_WIDTH = 9,
    parameter logic [31:0] DIGIT_ADDR     = 32'h40000010,
    parameter int unsigned DIGIT_WIDTH    = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   MemRd,
    input  logic                   MemWr,
    input  logic [1:0]             MemSize,
    input  logic                   MemSigned,
    input  logic [31:0]            Addr,
    input  logic [31:0]            WrData,
    output logic [31:0]            RdData,
    output logic                   Misalign,
    output logic                   Busy,
    output logic [DIGIT_WIDTH-1:0] Digit
);

    localparam int unsigned RAM_SIZE = 2 ** RAM_ADDR_WIDTH;

    logic [31:0] mem [RAM_SIZE];

    logic                      is_word, is_half, misalign, in_range, is_digit, run;
    logic                      store_ram, store_digit, load_ok;
    logic [RAM_ADDR_WIDTH-1:0] idx, wr_addr;
    logic [3:0]                be, wr_be;
    logic [31:0]               wdata_rep, wr_data;

    logic                      rd_valid_q, rd_digit_q, rd_signed_q;
    logic [1:0]                rd_lane_q, rd_size_q;
    logic [31:0]               rd_word_q;
    logic [DIGIT_WIDTH-1:0]    digit_snap_q;

    // Reserved size (11) behaves as word.
    assign is_word  = MemSize[1];
    assign is_half  = (MemSize == 2'b01);
    assign misalign = (is_half & Addr[0]) | (is_word & (Addr[1:0] != 2'b00));
    assign in_range = (Addr[31:RAM_ADDR_WIDTH+2] == '0);
    assign is_digit = (Addr == DIGIT_ADDR) & is_word;
    assign idx      = Addr[RAM_ADDR_WIDTH+1:2];

    always_comb begin
        be        = 4'b0000;
        wdata_rep = WrData;
        if (is_word) begin
            be = 4'b1111;
        end else if (is_half) begin
            be        = Addr[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{WrData[15:0]}};
        end else begin
            be        = 4'b0001 << Addr[1:0];
            wdata_rep = {4{WrData[7:0]}};
        end
    end

    assign store_ram   = run & ~misalign & MemWr & in_range;
    assign store_digit = run & ~misalign & MemWr & is_digit;
    assign load_ok     = run & ~misalign & MemRd & (in_range | is_digit);

`ifdef DATA_MEM_CLEAR_ON_RST_EN
    typedef enum logic {StClear, StRun} state_e;
    state_e                    state_q;
    logic [RAM_ADDR_WIDTH-1:0] ptr_q;

    assign run  = (state_q == StRun);
    assign Busy = (state_q == StClear);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StClear;
            ptr_q   <= '0;
        end else if (state_q == StClear) begin
            ptr_q <= ptr_q + 1'b1;
            if (ptr_q == '1) state_q <= StRun;
        end
    end

    assign wr_addr = Busy ? ptr_q : idx;
    assign wr_be   = Busy ? 4'b1111 : (store_ram ? be : 4'b0000);
    assign wr_data = Busy ? 32'h0 : wdata_rep;
`else
    assign run     = 1'b1;
    assign Busy    = 1'b0;
    assign wr_addr = idx;
    assign wr_be   = store_ram ? be : 4'b0000;
    assign wr_data = wdata_rep;
`endif

    // Plain BRAM port: byte-enable write, read-first registered read, no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
        rd_word_q <= mem[idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q   <= 1'b0;
            rd_digit_q   <= 1'b0;
            rd_signed_q  <= 1'b0;
            rd_lane_q    <= 2'b00;
            rd_size_q    <= 2'b00;
            digit_snap_q <= '0;
            Misalign     <= 1'b0;
            Digit        <= '0;
        end else begin
            rd_valid_q   <= load_ok;
            rd_digit_q   <= is_digit;
            rd_signed_q  <= MemSigned;
            rd_lane_q    <= Addr[1:0];
            rd_size_q    <= MemSize;
            digit_snap_q <= Digit;
            Misalign     <= run & (MemRd | MemWr) & misalign;
            if (store_digit) Digit <= WrData[DIGIT_WIDTH-1:0];
        end
    end

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        RdData = 32'h0;
        byte_v = rd_word_q[8*rd_lane_q +: 8];
        half_v = rd_lane_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];
        if (rd_valid_q) begin
            if (rd_digit_q) begin
                RdData = 32'(digit_snap_q);
            end else begin
                case (rd_size_q)
                    2'b00:   RdData = {{24{rd_signed_q & byte_v[7]}}, byte_v};
                    2'b01:   RdData = {{16{rd_signed_q & half_v[15]}}, half_v};
                    default: RdData = rd_word_q;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_data_mem_bytelane.sv
// Scoreboard bench for data_mem_bytelane; expectations queued at drive time, popped after the edge.
module tb_data_mem_bytelane;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MemRd = 1'b0, MemWr = 1'b0, MemSigned = 1'b0;
    logic [1:0]  MemSize = 2'b10;
    logic [31:0] Addr = '0, WrData = '0;
    logic [31:0] RdData;
    logic        Misalign, Busy;
    logic [11:0] Digit;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_rd_q[$];
    logic        exp_mis_q[$];
    string       tag_q[$];

    data_mem_bytelane dut (
        .clk      (clk),
        .rst      (rst),
        .MemRd    (MemRd),
        .MemWr    (MemWr),
        .MemSize  (MemSize),
        .MemSigned(MemSigned),
        .Addr     (Addr),
        .WrData   (WrData),
        .RdData   (RdData),
        .Misalign (Misalign),
        .Busy     (Busy),
        .Digit    (Digit)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One bus cycle: drive, queue the expected next-cycle output, compare after the edge.
    task automatic access(input string tag, input logic rd, input logic wr, input logic [1:0] size,
                          input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, input logic exp_mis);
        @(negedge clk);
        MemRd = rd; MemWr = wr; MemSize = size; MemSigned = sgn; Addr = addr; WrData = wdata;
        exp_rd_q.push_back(exp_rd);
        exp_mis_q.push_back(exp_mis);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        begin
            string t;
            logic [31:0] e_rd;
            logic e_mis;
            t = tag_q.pop_front();
            e_rd = exp_rd_q.pop_front();
            e_mis = exp_mis_q.pop_front();
            check_eq({t, "_rd"}, RdData, e_rd);
            check_eq({t, "_mis"}, {31'b0, Misalign}, {31'b0, e_mis});
        end
    endtask

    task automatic store(input string tag, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata);
        access(tag, 1'b0, 1'b1, size, 1'b0, addr, wdata, 32'h0, 1'b0);
    endtask

    task automatic load(input string tag, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] exp_rd);
        access(tag, 1'b1, 1'b0, size, sgn, addr, 32'h0, exp_rd, 1'b0);
    endtask

    task automatic idle(input string tag);
        access(tag, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    endtask

`ifdef DATA_MEM_CLEAR_ON_RST_EN
    // Deasserts rst at a negedge and counts cycles of Busy, holding a load to 0x10 meanwhile.
    task automatic sweep(input string tag);
        int cnt;
        cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        MemRd = 1'b1; MemWr = 1'b0; MemSize = 2'b10; Addr = 32'h10;
        while (Busy && cnt < 2000) begin
            cnt++;
            @(negedge clk);
            if (cnt == 100) check_eq({tag, "_busy_rd"}, RdData, 32'h0);
        end
        MemRd = 1'b0;
        check_eq({tag, "_busy_cycles"}, cnt, 512);
    endtask
`endif

    initial begin
        repeat (2) @(negedge clk);
        check_eq("rst_rd", RdData, 32'h0);
        check_eq("rst_mis", {31'b0, Misalign}, 32'h0);
        check_eq("rst_digit", {20'b0, Digit}, 32'h0);
`ifdef DATA_MEM_CLEAR_ON_RST_EN
        check_eq("rst_busy", {31'b0, Busy}, 32'h1);
        sweep("sweep1");
        load("clr_1fc", 2'b10, 1'b0, 32'h1FC, 32'h0);
`else
        check_eq("rst_busy", {31'b0, Busy}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
`endif
        // Byte lanes
        store("st_20", 2'b10, 32'h20, 32'h11223344);
        store("stb_21", 2'b00, 32'h21, 32'h000000AB);
        load("ld_20", 2'b10, 1'b0, 32'h20, 32'h1122AB44);
        store("sth_22", 2'b01, 32'h22, 32'h0000BEEF);
        load("ld_20h", 2'b10, 1'b0, 32'h20, 32'hBEEFAB44);

        // Extension
        store("st_40", 2'b10, 32'h40, 32'h80FF7F01);
        store("st_44", 2'b10, 32'h44, 32'h55AA55AA);
        load("lbs_43", 2'b00, 1'b1, 32'h43, 32'hFFFFFF80);
        load("lbu_43", 2'b00, 1'b0, 32'h43, 32'h00000080);
        load("lhs_42", 2'b01, 1'b1, 32'h42, 32'hFFFF80FF);
        load("lhu_40", 2'b01, 1'b0, 32'h40, 32'h00007F01);
        load("lbs_40", 2'b00, 1'b1, 32'h40, 32'h00000001);
        load("lw_res", 2'b11, 1'b1, 32'h40, 32'h80FF7F01);

        // Misalign
        access("mis_st", 1'b0, 1'b1, 2'b10, 1'b0, 32'h42, 32'hDEADBEEF, 32'h0, 1'b1);
        idle("mis_clr");
        load("mis_40", 2'b10, 1'b0, 32'h40, 32'h80FF7F01);
        load("mis_44", 2'b10, 1'b0, 32'h44, 32'h55AA55AA);
        access("mis_lh", 1'b1, 1'b0, 2'b01, 1'b1, 32'h41, 32'h0, 32'h0, 1'b1);

        // Read-first on simultaneous read/write
        store("st_60", 2'b10, 32'h60, 32'd5);
        access("rw_60", 1'b1, 1'b1, 2'b10, 1'b0, 32'h60, 32'd9, 32'd5, 1'b0);
        load("ld_60", 2'b10, 1'b0, 32'h60, 32'd9);

        // MMIO digit
        store("st_dig", 2'b10, 32'h40000010, 32'h00000ABC);
        check_eq("digit", {20'b0, Digit}, 32'h00000ABC);
        load("ld_dig", 2'b10, 1'b0, 32'h40000010, 32'h00000ABC);
        store("stb_dig", 2'b00, 32'h40000010, 32'h00000055);
        check_eq("digit_keep", {20'b0, Digit}, 32'h00000ABC);

        // Out of range: must not alias onto word 0
        store("st_0", 2'b10, 32'h0, 32'hCAFEF00D);
        store("st_800", 2'b10, 32'h800, 32'h12345678);
        load("ld_800", 2'b10, 1'b0, 32'h800, 32'h0);
        load("ld_0", 2'b10, 1'b0, 32'h0, 32'hCAFEF00D);
        idle("end_idle");

`ifdef DATA_MEM_CLEAR_ON_RST_EN
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        sweep("sweep2");
        load("clr_20", 2'b10, 1'b0, 32'h20, 32'h0);
        check_eq("clr_digit", {20'b0, Digit}, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
